// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding for alu_seq.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_ASR = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential signed shift-add multiplier: one partial product per cycle, W steps.
module alu_mul_seq #(
  parameter int W = 10
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_done,
  output logic [2*W-1:0] o_prod,
  output logic           o_ovf
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] acc_q, mcand_q, pp;
  logic [W-1:0]   mplr_q;
  logic [CW-1:0]  cnt_q;
  logic           run_q, done_q;
  logic           last;

  assign last = (cnt_q == CW'(W-1));

  // The multiplier's MSB has negative weight, so its partial product is subtracted.
  always_comb begin
    pp = '0;
    if (mplr_q[0]) pp = last ? (~mcand_q + 1'b1) : mcand_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_start) begin
        acc_q   <= '0;
        mcand_q <= {{W{i_a[W-1]}}, i_a};
        mplr_q  <= i_b;
        cnt_q   <= '0;
        run_q   <= 1'b1;
      end else if (run_q) begin
        acc_q   <= acc_q + pp;
        mcand_q <= mcand_q << 1;
        mplr_q  <= mplr_q >> 1;
        cnt_q   <= cnt_q + 1'b1;
        if (last) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign o_done = done_q;
  assign o_prod = acc_q;
  // Fits in W signed bits only when the top W+1 bits are all equal.
  assign o_ovf  = ~((&acc_q[2*W-1:W-1]) | ~(|acc_q[2*W-1:W-1]));

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with status flags and a multi-cycle signed multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W      = 10,
  parameter int MUL_EN = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_arg0,
  input  logic [W-1:0] i_arg1,
  input  logic [2:0]   i_oper,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_result,
  output logic [3:0]   o_flag
);

  state_e         state_q, state_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   result_q, result_d;
  logic [3:0]     flag_q, flag_d;

  logic           accept, is_mul;
  logic [W-1:0]   alu_res, ones;
  logic [3:0]     alu_flg, mul_flg;
  logic [W:0]     sum, diff;
  logic [W+31:0]  amt;
  logic           amt_big, c, v;
  logic           mul_done, mul_ovf;
  logic [2*W-1:0] mul_prod;

  assign o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
  assign accept  = i_valid && o_ready;
  assign is_mul  = (MUL_EN != 0) && (i_oper == OP_MUL);

  always_comb begin
    ones    = '1;
    sum     = {1'b0, i_arg0} + {1'b0, i_arg1};
    diff    = {1'b0, i_arg0} - {1'b0, i_arg1};
    amt     = (W+32)'(i_arg1);
    amt_big = (amt >= (W+32)'(W));
    alu_res = '0;
    c       = 1'b0;
    v       = 1'b0;
    case (i_oper)
      OP_ADD: begin
        alu_res = sum[W-1:0];
        c       = sum[W];
        v       = (i_arg0[W-1] == i_arg1[W-1]) && (sum[W-1] != i_arg0[W-1]);
      end
      OP_SUB: begin
        alu_res = diff[W-1:0];
        c       = diff[W];
        v       = (i_arg0[W-1] != i_arg1[W-1]) && (diff[W-1] != i_arg0[W-1]);
      end
      OP_AND: alu_res = i_arg0 & i_arg1;
      OP_OR:  alu_res = i_arg0 | i_arg1;
      OP_XOR: alu_res = i_arg0 ^ i_arg1;
      OP_SHL: begin
        alu_res = amt_big ? '0 : (i_arg0 << i_arg1);
        c       = amt_big ? (|i_arg0) : (|(i_arg0 & ~(ones >> i_arg1)));
      end
      OP_ASR: begin
        alu_res = amt_big ? {W{i_arg0[W-1]}} : W'($signed(i_arg0) >>> i_arg1);
        c       = amt_big ? (|i_arg0) : (|(i_arg0 & ~(ones << i_arg1)));
      end
      default: alu_res = '0;
    endcase
    alu_flg        = '0;
    alu_flg[FLG_Z] = (alu_res == '0);
    alu_flg[FLG_N] = alu_res[W-1];
    alu_flg[FLG_C] = c;
    alu_flg[FLG_V] = v;
    // Illegal opcode (multiply disabled) reports no flags at all, not even Z.
    if (i_oper == OP_MUL) alu_flg = '0;
  end

  always_comb begin
    mul_flg        = '0;
    mul_flg[FLG_Z] = (mul_prod[W-1:0] == '0);
    mul_flg[FLG_N] = mul_prod[W-1];
    mul_flg[FLG_V] = mul_ovf;
  end

  alu_mul_seq #(.W(W)) u_mul (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (accept && is_mul),
    .i_a     (i_arg0),
    .i_b     (i_arg1),
    .o_done  (mul_done),
    .o_prod  (mul_prod),
    .o_ovf   (mul_ovf)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    result_d = result_q;
    flag_d   = flag_q;
    case (state_q)
      BUSY: begin
        if (mul_done) begin
          state_d  = DONE;
          valid_d  = 1'b1;
          result_d = mul_prod[W-1:0];
          flag_d   = mul_flg;
        end
      end
      default: begin
        if (accept) begin
          if (is_mul) begin
            state_d = BUSY;
            valid_d = 1'b0;
          end else begin
            state_d  = DONE;
            valid_d  = 1'b1;
            result_d = alu_res;
            flag_d   = alu_flg;
          end
        end else if ((state_q == DONE) && i_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      flag_q   <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_flag   = flag_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors, monitor pops on each result transfer.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [W-1:0] i_arg0 = '0;
  logic [W-1:0] i_arg1 = '0;
  logic [2:0]   i_oper = '0;
  logic         o_valid;
  logic         i_ready = 1'b1;
  logic [W-1:0] o_result;
  logic [3:0]   o_flag;

  typedef struct packed {
    logic [W-1:0] r;
    logic [3:0]   f;
  } exp_t;

  exp_t sb[$];
  int   pops[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  alu_seq #(.W(W), .MUL_EN(1)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_arg0   (i_arg0),
    .i_arg1   (i_arg1),
    .i_oper   (i_oper),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_flag   (o_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected result: got %0h/%b, expected none", o_result, o_flag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(o_result), 32'(e.r));
        chk("flag", 32'(o_flag), 32'(e.f));
        pops.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [2:0] op, input int a, input int b, input logic push,
                      input logic [W-1:0] er, input logic [3:0] ef);
    int n;
    n = 0;
    @(negedge clk);
    i_valid = 1'b1;
    i_oper  = op;
    i_arg0  = W'(a);
    i_arg1  = W'(b);
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      chk("accept timeout", 32'(o_ready), 32'd1);
    end else begin
      if (push) sb.push_back({er, ef});
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_arg0  = '1;
      i_arg1  = '1;
      i_oper  = OP_XOR;
    end
  endtask

  initial begin
    int n;
    logic rdy_seen;
    logic [W-1:0] hr;
    logic [3:0]   hf;

    #1 rst = 1'b1;
    #2;
    chk("reset o_valid", 32'(o_valid), 32'd0);
    chk("reset o_result", 32'(o_result), 32'd0);
    chk("reset o_flag", 32'(o_flag), 32'd0);
    chk("reset o_ready", 32'(o_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    send(OP_ADD, -512, -512, 1'b1, 10'd0, 4'b1101);
    @(negedge clk);
    chk("add latency", 32'(o_valid), 32'd1);
    send(OP_ADD, 0, 1, 1'b1, 10'd1, 4'b0000);
    @(negedge clk);
    chk("add latency 2", 32'(o_valid), 32'd1);
    send(OP_SUB, 1, 10, 1'b1, 10'h3F7, 4'b0110);
    send(OP_SUB, 8, 8, 1'b1, 10'd0, 4'b0001);
    send(OP_SHL, 2, 1, 1'b1, 10'd4, 4'b0000);
    send(OP_SHL, 513, 1, 1'b1, 10'd2, 4'b0100);
    send(OP_ASR, -8, 2, 1'b1, 10'h3FE, 4'b0010);
    send(OP_ASR, -8, 12, 1'b1, 10'h3FF, 4'b0110);

    send(OP_AND, 5, 3, 1'b1, 10'd1, 4'b0000);
    send(OP_OR, 7, 2, 1'b1, 10'd7, 4'b0000);
    send(OP_XOR, 7, 2, 1'b1, 10'd5, 4'b0000);
    repeat (2) @(negedge clk);
    if (pops.size() >= 3) begin
      chk("b2b spacing 1", 32'(pops[pops.size()-2] - pops[pops.size()-3]), 32'd1);
      chk("b2b spacing 2", 32'(pops[pops.size()-1] - pops[pops.size()-2]), 32'd1);
    end else begin
      chk("b2b result count", 32'(pops.size()), 32'd3);
    end

    send(OP_MUL, 25, -3, 1'b1, 10'h3B5, 4'b0010);
    n = 0;
    rdy_seen = 1'b0;
    @(negedge clk);
    while (!o_valid && n < 50) begin
      if (o_ready) rdy_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("mul latency", 32'(n), 32'd11);
    chk("o_ready in busy", 32'(rdy_seen), 32'd0);

    @(posedge clk);
    #1 i_ready = 1'b0;
    send(OP_MUL, 40, 20, 1'b1, 10'h320, 4'b1010);
    n = 0;
    while (!o_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mul2 valid", 32'(o_valid), 32'd1);
    hr = 10'h320;
    hf = 4'b1010;
    repeat (3) begin
      @(negedge clk);
      chk("hold valid", 32'(o_valid), 32'd1);
      chk("hold result", 32'(o_result), 32'(hr));
      chk("hold flag", 32'(o_flag), 32'(hf));
    end
    @(posedge clk);
    #1 i_ready = 1'b1;
    repeat (2) @(negedge clk);

    send(OP_MUL, 25, -3, 1'b0, 10'd0, 4'b0000);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("busy reset o_valid", 32'(o_valid), 32'd0);
    chk("busy reset o_result", 32'(o_result), 32'd0);
    chk("busy reset o_flag", 32'(o_flag), 32'd0);
    chk("busy reset o_ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post reset o_ready", 32'(o_ready), 32'd1);
    send(OP_ADD, 0, 1, 1'b1, 10'd1, 4'b0000);
    repeat (20) @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 10-bit combinational ALU. It registers each operation, adds arithmetic shift right and a multi-cycle signed multiply, and carries the four status flags alongside every result. It sits between an operand producer and a result consumer, each with its own valid/ready pair. Default W=10 keeps results bit-identical to the existing ALU for the shared opcodes.

## Interface
- W, 10: operand/result width, ≥4
- MUL_EN, 1: 1 = opcode 100 is multiply; 0 = opcode 100 is illegal
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  operand beat valid
- o_ready  out  1  block accepts operand beat this cycle
- i_arg0  in  W  signed operand A
- i_arg1  in  W  signed operand B; shift amount for shift ops, read as unsigned
- i_oper  in  3  opcode
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_result  out  W  signed result
- o_flag  out  4  [0]=Z zero, [1]=N sign, [2]=C carry/borrow/shift-out, [3]=V signed overflow

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 SHL, 100 MUL, 101 ASR, 110 OR, 111 XOR.
- ADD: computed in W+1 bits. C = unsigned carry-out. V = signed overflow.
- SUB: A−B. C = unsigned borrow (A<B). V = signed overflow.
- AND/OR/XOR: bitwise. C=0, V=0.
- SHL: A<<B. ASR: A>>>B. An amount ≥W gives 0 (SHL) or all sign bits (ASR). C=1 if any 1-bit was shifted out. V=0.
- MUL: low W bits of the signed 2W-bit product. V=1 if the product does not fit in W signed bits. C=0. Computed by shift-add, one partial-product step per cycle, W steps.
- Opcode 100 with MUL_EN=0: result 0, o_flag 4'b0000, single-cycle latency.
- Z and N always come from o_result.
- FSM states: IDLE, BUSY (multiply only), DONE.
  - IDLE → DONE on accept of a non-MUL beat.
  - IDLE → BUSY on accept of MUL; BUSY → DONE after W cycles.
  - DONE → IDLE when i_ready=1 and no new accept.
  - DONE → DONE/BUSY when i_ready=1 and a new beat is accepted in the same cycle.
- Accept rule: accept happens when i_valid && o_ready. o_ready = IDLE || (DONE && i_ready). o_ready is 0 in BUSY.
- Beats presented while o_ready=0 are not consumed. The producer must hold them.
- o_result/o_flag hold stable while o_valid && !i_ready.

## Timing
- Reset values: o_valid=0, o_result=0, o_flag=0, FSM=IDLE. o_ready is 1 while in reset.
- Non-MUL latency: o_valid rises on the edge that accepts the beat (visible in the next cycle).
- Back-to-back throughput with i_ready=1: one result per cycle.
- MUL latency: o_valid rises W+1 edges after the accept edge.
- An i_rst assertion at any time (including BUSY or DONE) takes effect immediately without a clock. The in-flight operation and any held result are discarded, never delivered.
- i_valid and i_oper are sampled only on the accept edge. Operand changes after acceptance do not affect the result.

## Structure
- Package alu_pkg holds:
  - opcode localparams OP_ADD…OP_XOR
  - flag indices FLG_Z, FLG_N, FLG_C, FLG_V
  - the state enum (IDLE, BUSY, DONE)
- Sub-module alu_mul_seq: sequential signed shift-add multiplier, with start/done handshake, W parameter, 2W-bit product and an overflow output.
- Top-level alu_seq contains the single-cycle datapath, flag logic, FSM and output registers.

## Test plan
- ADD −512 + −512 (W=10) → o_result 0, o_flag 4'b1101. Then ADD 0+1 → 1, 4'b0000. Each o_valid is one cycle after accept.
- SUB 1−10 → −9, 4'b0110. SUB 8−8 → 0, 4'b0001.
- Shifts: SHL 2<<1 → 4, 4'b0000. SHL 10'b1000000001<<1 → 2, 4'b0100. ASR −8>>>2 → −2, 4'b0010. ASR −8 by 12 → −1, 4'b0110.
- Back-to-back AND 5&3, OR 7|2, XOR 7^2 with i_ready=1 → 1, 7, 5 on three consecutive cycles, each with flags 4'b0000.
- MUL 25×−3 → −75, 4'b0010, with o_valid exactly 11 edges after accept and o_ready=0 throughout BUSY. MUL 40×20 → −224, 4'b1010; hold i_ready=0 for 3 cycles and the result stays stable.
- Assert i_rst on the 4th BUSY cycle of a MUL → o_valid=0, o_result=0, o_flag=0 immediately. After release, o_ready=1 and ADD 0+1 → 1 with no stale MUL result delivered.
